// File: rtl/ram_port_arbiter_if.sv
// Requester and SRAM-side bus of the pixel RAM arbiter.
// The arbiter uses the slave view; the clients and the SRAM use the master view.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output rd_done, rd_data, wr_done, mem_addr, mem_wdata, mem_ren, mem_wen, busy
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  rd_done, rd_data, wr_done, mem_addr, mem_wdata, mem_ren, mem_wen, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port pixel SRAM between window-buffer reads and filtered-pixel
// write-back. Reads win by default; a pending write is forced after MAX_WAIT reads.
//
// state    | meaning
// IDLE     | waiting; the only state where requests are sampled
// ISSUE_RD | mem_ren high for one cycle
// RD_WAIT  | counting RD_LAT cycles until mem_rdata is valid
// RD_DONE  | rd_done pulse with captured rd_data
// ISSUE_WR | mem_wen and wr_done high for one cycle
module ram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               n_rst,
  ram_port_arbiter_if.slave bus
);
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {IDLE, ISSUE_RD, RD_WAIT, RD_DONE, ISSUE_WR} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              force_wr;

  // a write goes first when it is alone or has been bypassed MAX_WAIT times
  assign force_wr = bus.wr_req && (!bus.rd_req || (wait_cnt == WAIT_MAX));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      wait_cnt      <= '0;
      bus.rd_done   <= 1'b0;
      bus.rd_data   <= {DATA_W{1'b0}};
      bus.wr_done   <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.mem_ren   <= 1'b0;
      bus.mem_wen   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (force_wr) begin
            state         <= ISSUE_WR;
            bus.mem_wen   <= 1'b1;
            bus.wr_done   <= 1'b1;
            bus.mem_addr  <= bus.wr_addr;
            bus.mem_wdata <= bus.wr_data;
            wait_cnt      <= '0;
            bus.busy      <= 1'b1;
          end else if (bus.rd_req) begin
            state        <= ISSUE_RD;
            bus.mem_ren  <= 1'b1;
            bus.mem_addr <= bus.rd_addr;
            bus.busy     <= 1'b1;
          end
        end
        ISSUE_RD: begin
          bus.mem_ren <= 1'b0;
          lat_cnt     <= LAT_LOAD;
          state       <= RD_WAIT;
          if (bus.wr_req && (wait_cnt != WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            bus.rd_data <= bus.mem_rdata;
            bus.rd_done <= 1'b1;
            state       <= RD_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RD_DONE: begin
          bus.rd_done <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        ISSUE_WR: begin
          bus.mem_wen <= 1'b0;
          bus.wr_done <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          bus.mem_ren <= 1'b0;
          bus.mem_wen <= 1'b0;
          bus.rd_done <= 1'b0;
          bus.wr_done <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: scoreboarded reads/writes, grant order, latencies,
// reset abort, and an RD_LAT=1 build.
module tb_ram_port_arbiter;
  localparam int RD_LAT = 2;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  ram_port_arbiter_if bus ();
  ram_port_arbiter_if bus1 ();

  ram_port_arbiter u_dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  ram_port_arbiter #(.RD_LAT(1)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_q [$];
  logic [63:0] wr_q [$];
  logic [31:0] rd1_q [$];
  byte         grant_log [$];
  int rd_left = 0, wr_left = 0;
  int ren_cyc = 0, wen_cyc = 0, rd_done_cyc = 0, rd_done_cnt = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hA1B2C3D4 : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // SRAM models: data appears RD_LAT cycles after the mem_ren cycle, garbage otherwise
  logic [3:0]  ren_h, ren1_h;
  logic [31:0] addr_h [4];
  logic [31:0] addr1_h [4];
  initial begin
    ren_h = '0;
    ren1_h = '0;
    bus.mem_rdata = BAD;
    bus1.mem_rdata = BAD;
    forever begin
      @(negedge clk);
      ren_h  = {ren_h[2:0], bus.mem_ren};
      ren1_h = {ren1_h[2:0], bus1.mem_ren};
      for (int k = 3; k > 0; k--) begin
        addr_h[k]  = addr_h[k-1];
        addr1_h[k] = addr1_h[k-1];
      end
      addr_h[0]  = bus.mem_addr;
      addr1_h[0] = bus1.mem_addr;
      bus.mem_rdata  = ren_h[RD_LAT] ? mem_val(addr_h[RD_LAT]) : BAD;
      bus1.mem_rdata = ren1_h[1] ? mem_val(addr1_h[1]) : BAD;
    end
  end

  task automatic start_rd(input logic [31:0] a, input int n);
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    rd_left     = n;
    repeat (n) rd_q.push_back(mem_val(a));
  endtask

  task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input int n);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    wr_left     = n;
    repeat (n) wr_q.push_back({a, d});
  endtask

  // one cycle: observe the main DUT at the falling edge and act as both requesters
  task automatic tick();
    @(negedge clk);
    if (n_rst) begin
      if (bus.mem_ren || bus.mem_wen)
        check_val("strobe_excl", {63'd0, bus.mem_ren & bus.mem_wen}, 64'd0);
      if (bus.mem_ren) begin
        grant_log.push_back("R");
        ren_cyc = cyc;
        check_val("ren_addr", bus.mem_addr, bus.rd_addr);
      end
      if (bus.mem_wen) begin
        grant_log.push_back("W");
        wen_cyc = cyc;
      end
      if (bus.rd_done) begin
        rd_done_cyc = cyc;
        rd_done_cnt++;
        check_val("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check_val("rd_data", bus.rd_data, rd_q.pop_front());
        if (rd_left > 0) rd_left--;
        if (rd_left == 0) bus.rd_req = 1'b0;
      end
      if (bus.wr_done) begin
        check_val("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) check_val("wr_bus", {bus.mem_addr, bus.mem_wdata}, wr_q.pop_front());
        check_val("wr_wen", bus.mem_wen, 1);
        check_val("wait_cnt_clr", u_dut.wait_cnt, 0);
        if (wr_left > 0) wr_left--;
        if (wr_left == 0) bus.wr_req = 1'b0;
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((rd_left != 0 || wr_left != 0 || bus.busy) && k < 100);
    check_val({tag, "_finished"}, k < 100, 1);
  endtask

  task automatic compare_log(input string tag, input string s);
    check_val({tag, "_len"}, grant_log.size(), s.len());
    for (int i = 0; i < s.len() && i < grant_log.size(); i++)
      check_val({tag, "_grant"}, grant_log[i], s[i]);
  endtask

  initial begin
    int t0, d1, d2, n_done, k, cnt_save;
    logic wen1_seen;
    bus.rd_req = 0;  bus.rd_addr = '0;  bus.wr_req = 0;  bus.wr_addr = '0;  bus.wr_data = '0;
    bus1.rd_req = 0; bus1.rd_addr = '0; bus1.wr_req = 0; bus1.wr_addr = '0; bus1.wr_data = '0;

    repeat (3) @(negedge clk);
    check_val("rst_ctl", {bus.rd_done, bus.wr_done, bus.mem_ren, bus.mem_wen, bus.busy}, 0);
    check_val("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
    check_val("rst_rdata", bus.rd_data, 0);
    n_rst = 1'b1;
    tick();
    check_val("idle_busy", bus.busy, 0);

    // single read
    tick(); t0 = cyc; start_rd(32'h10, 1);
    wait_quiet("t1");
    check_val("t1_ren_lat", ren_cyc - t0, 1);
    check_val("t1_done_lat", rd_done_cyc - t0, 4);
    check_val("t1_data_hold", bus.rd_data, 32'hA1B2C3D4);

    // single write
    tick(); t0 = cyc; start_wr(32'h20, 32'h55AA55AA, 1);
    tick();
    check_val("t2_wen_done", {bus.mem_wen, bus.wr_done}, 2'b11);
    check_val("t2_wr_bus", {bus.mem_addr, bus.mem_wdata}, {32'h20, 32'h55AA55AA});
    tick();
    check_val("t2_busy_low", bus.busy, 0);
    check_val("t2_wr_lat", wen_cyc - t0, 1);

    // simultaneous requests: read first
    tick(); grant_log.delete(); t0 = cyc;
    start_rd(32'h30, 1); start_wr(32'h40, 32'h12345678, 1);
    wait_quiet("t3");
    check_val("t3_rd_lat", rd_done_cyc - t0, 4);
    check_val("t3_wr_lat", wen_cyc - t0, 6);
    compare_log("t3", "RW");

    // both held: bypass counter forces a write after four reads
    tick(); grant_log.delete();
    start_rd(32'h50, 8); start_wr(32'h60, 32'hCAFEF00D, 2);
    wait_quiet("t4");
    compare_log("t4", "RRRRWRRRRW");
    check_val("t4_wait_end", u_dut.wait_cnt, 0);

    // reset while waiting for read data
    tick(); t0 = cyc; start_rd(32'h70, 1);
    tick(); tick();
    check_val("t5_in_wait", {bus.busy, bus.mem_ren, bus.rd_done}, 3'b100);
    n_rst = 1'b0; bus.rd_req = 1'b0; rd_left = 0; rd_q.delete();
    #1;
    check_val("t5_rst_ctl", {bus.rd_done, bus.wr_done, bus.mem_ren, bus.mem_wen, bus.busy}, 0);
    check_val("t5_rst_bus", {bus.mem_addr, bus.rd_data}, 0);
    cnt_save = rd_done_cnt;
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (4) tick();
    check_val("t5_no_done", rd_done_cnt, cnt_save);
    t0 = cyc; start_rd(32'h74, 1);
    wait_quiet("t5b");
    check_val("t5_done_lat", rd_done_cyc - t0, 4);

    // RD_LAT=1 build, back-to-back reads
    tick(); t0 = cyc;
    bus1.rd_addr = 32'h0; bus1.rd_req = 1'b1; rd1_q.push_back(mem_val(32'h0));
    n_done = 0; wen1_seen = 1'b0; k = 0; d1 = 0; d2 = 0;
    while (n_done < 2 && k < 40) begin
      tick(); k++;
      if (bus1.mem_wen) wen1_seen = 1'b1;
      if (bus1.rd_done) begin
        n_done++;
        if (rd1_q.size() != 0) check_val("t6_data", bus1.rd_data, rd1_q.pop_front());
        if (n_done == 1) begin
          d1 = cyc;
          bus1.rd_addr = 32'h4;
          rd1_q.push_back(mem_val(32'h4));
        end else begin
          d2 = cyc;
          bus1.rd_req = 1'b0;
        end
      end
    end
    check_val("t6_done_count", n_done, 2);
    check_val("t6_first_lat", d1 - t0, 3);
    check_val("t6_second_gap", d2 - d1, 4);
    check_val("t6_no_wen", wen1_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
